// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem fetch at a
// time, and buffers returned words in a 2-entry FIFO whose head feeds IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] PC_4_out,
    output logic [31:0] instr_out,
    output logic [1:0]  fsm_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] buf_pc_q    [2];
    logic [31:0] buf_instr_q [2];

    logic        push;
    logic        pop;
    logic [1:0]  next_cnt;
    logic [31:0] redirect_tgt;

    // Handshake: a fetch is offered while imem_req_out=1 with imem_addr_out held
    // stable; it completes on the first edge where imem_ack_in=1 is sampled.
    assign imem_req_out  = (state_q == ST_REQ) || (state_q == ST_DROP);
    assign imem_addr_out = req_addr_q;
    assign fsm_state_o   = state_q;

    assign PC_4_out  = (count_q != 2'd0) ? buf_pc_q[0] + 32'd4 : 32'd0;
    assign instr_out = (count_q != 2'd0) ? buf_instr_q[0] : 32'd0;

    assign redirect_tgt = {redirect_pc_in[31:2], 2'b00};
    assign pop      = hazard_in && (count_q != 2'd0) && !redirect_in;
    assign push     = imem_ack_in && (state_q == ST_REQ) && !redirect_in;
    assign next_cnt = count_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        count_d    = next_cnt;
        if (redirect_in) begin
            count_d    = 2'd0;
            fetch_pc_d = redirect_tgt;
            // A request already on the bus cannot be withdrawn; wait out its ack.
            if ((state_q != ST_IDLE) && !imem_ack_in) begin
                state_d = ST_DROP;
            end else begin
                state_d    = ST_REQ;
                req_addr_d = redirect_tgt;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q < 2'd2) begin
                        state_d    = ST_REQ;
                        req_addr_d = fetch_pc_q;
                    end
                end
                ST_REQ: begin
                    if (imem_ack_in) begin
                        fetch_pc_d = req_addr_q + 32'd4;
                        if (next_cnt < 2'd2) begin
                            req_addr_d = req_addr_q + 32'd4;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (imem_ack_in) begin
                        state_d    = ST_REQ;
                        req_addr_d = fetch_pc_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= 2'd0;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (pop) begin
                if (push && (count_q == 2'd1)) begin
                    buf_pc_q[0]    <= req_addr_q;
                    buf_instr_q[0] <= imem_data_in;
                end else begin
                    buf_pc_q[0]    <= buf_pc_q[1];
                    buf_instr_q[0] <= buf_instr_q[1];
                end
                if (push && (count_q == 2'd2)) begin
                    buf_pc_q[1]    <= req_addr_q;
                    buf_instr_q[1] <= imem_data_in;
                end
            end else if (push) begin
                if (count_q == 2'd0) begin
                    buf_pc_q[0]    <= req_addr_q;
                    buf_instr_q[0] <= imem_data_in;
                end else begin
                    buf_pc_q[1]    <= req_addr_q;
                    buf_instr_q[1] <= imem_data_in;
                end
            end
        end
    end

endmodule
